srff_bank_arbiter: RTL and testbench

SRFF_BANK_ARBITER -- requirements
Module: srff_bank_arbiter

---
 rtl/srff_pkg.sv | 21 ++
 rtl/srff_bank_arbiter_if.sv | 32 +++
 rtl/srff_cell.sv | 25 ++
 rtl/srff_bank_arbiter.sv | 106 ++++++++++
 tb/tb_srff_bank_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/srff_pkg.sv
// Shared encodings and defaults for the SR flag bank arbiter.
// Opcodes, FSM states and bank sizing live here.
package srff_pkg;

    localparam int NFLAG_DEF = 8;
    localparam int IDX_W_DEF = 3;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_SET = 2'b01,
        OP_CLR = 2'b10,
        OP_TGL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

endpackage

// File: rtl/srff_bank_arbiter_if.sv
// Two-requester command bus for the SR flag bank.
// The requester side drives master, the arbiter uses slave.
interface srff_bank_arbiter_if #(
    parameter int IDX_W = srff_pkg::IDX_W_DEF
);
    import srff_pkg::*;

    logic             req0_valid;
    logic [1:0]       req0_op;
    logic [IDX_W-1:0] req0_idx;
    logic             req0_ready;

    logic             req1_valid;
    logic [1:0]       req1_op;
    logic [IDX_W-1:0] req1_idx;
    logic             req1_ready;

    modport master (
        output req0_valid, req0_op, req0_idx,
        input  req0_ready,
        output req1_valid, req1_op, req1_idx,
        input  req1_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_idx,
        output req0_ready,
        input  req1_valid, req1_op, req1_idx,
        output req1_ready
    );

endinterface

// File: rtl/srff_cell.sv
// One SR flip-flop flag cell with asynchronous active-low clear.
// s=r=0 holds; the bank never presents s=r=1.
module srff_cell (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q
);

    logic flag_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_q <= 1'b0;
        end else if (s) begin
            flag_q <= 1'b1;
        end else if (r) begin
            flag_q <= 1'b0;
        end
    end

    assign q = flag_q;

endmodule

// File: rtl/srff_bank_arbiter.sv
// Round-robin arbiter feeding a bank of SR flag cells.
// One command per three cycles: IDLE accepts, APPLY writes, SETTLE reports.
module srff_bank_arbiter
    import srff_pkg::*;
#(
    parameter int NFLAG = NFLAG_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    srff_bank_arbiter_if.slave bus,
    output logic [NFLAG-1:0]   q,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    op_e              op_q, op_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             idle;
    logic             gnt0;
    logic             gnt1;
    logic [NFLAG-1:0] s_vec;
    logic [NFLAG-1:0] r_vec;

    assign idle = (state_q == ST_IDLE);

    // ptr only breaks ties; a lone requester always wins
    assign gnt0 = bus.req0_valid & (~bus.req1_valid | ~ptr_q);
    assign gnt1 = bus.req1_valid & (~bus.req0_valid | ptr_q);

    assign bus.req0_ready = rst & idle & gnt0;
    assign bus.req1_ready = rst & idle & gnt1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt0 | gnt1) begin
                    state_d = ST_APPLY;
                    ptr_d   = gnt0;
                    op_d    = gnt1 ? op_e'(bus.req1_op) : op_e'(bus.req0_op);
                    idx_d   = gnt1 ? bus.req1_idx : bus.req0_idx;
                end
            end
            ST_APPLY:  state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            op_q    <= OP_NOP;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
        end
    end

    // TOGGLE drives exactly one of s/r from the current bit
    always_comb begin
        s_vec = '0;
        r_vec = '0;
        if (state_q == ST_APPLY) begin
            unique case (op_q)
                OP_SET: s_vec[idx_q] = 1'b1;
                OP_CLR: r_vec[idx_q] = 1'b1;
                OP_TGL: begin
                    s_vec[idx_q] = ~q[idx_q];
                    r_vec[idx_q] = q[idx_q];
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < NFLAG; i++) begin : g_cell
        srff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .s   (s_vec[i]),
            .r   (r_vec[i]),
            .q   (q[i])
        );
    end

    assign busy = ~idle;
    assign done = (state_q == ST_SETTLE);
    assign err  = done & (op_q == OP_NOP);

    a_no_sr: assert property (@(posedge clk) disable iff (!rst)
        (s_vec & r_vec) == '0);

endmodule

// File: tb/tb_srff_bank_arbiter.sv
// Scoreboard bench for the SR flag bank arbiter.
// A cycle model predicts readys/busy/done; results are queued at accept.
module tb_srff_bank_arbiter;

    typedef struct {
        logic [1:0] op;
        logic [2:0] idx;
    } cmd_t;

    typedef struct {
        logic [7:0] q;
        logic       err;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic       err;

    srff_bank_arbiter_if #(.IDX_W(3)) bus ();

    srff_bank_arbiter #(.NFLAG(8), .IDX_W(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .q    (q),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      tag, got, exp, cyc);
    endtask

    cmd_t cq0[$];
    cmd_t cq1[$];
    exp_t sb[$];
    int   acc_id[$];
    int   acc_cyc[$];
    int   n_acc0 = 0;
    int   n_acc1 = 0;

    logic [7:0] m_q;
    logic       m_ptr;
    int         m_cnt;
    logic       e_r0;
    logic       e_r1;
    exp_t       e;
    exp_t       ne;
    logic [1:0] a_op;
    logic [2:0] a_idx;

    function automatic logic [7:0] apply(input logic [7:0] cur,
                                         input logic [1:0] op,
                                         input logic [2:0] idx);
        logic [7:0] n;
        n = cur;
        case (op)
            2'b01: n[idx] = 1'b1;
            2'b10: n[idx] = 1'b0;
            2'b11: n[idx] = ~cur[idx];
            default: ;
        endcase
        return n;
    endfunction

    // reference model and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_q", 32'(q), 32'h0);
            chk("rst_rdy0", 32'(bus.req0_ready), 32'h0);
            chk("rst_rdy1", 32'(bus.req1_ready), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_done", 32'(done), 32'h0);
            chk("rst_err", 32'(err), 32'h0);
            m_q   = 8'h00;
            m_ptr = 1'b0;
            m_cnt = 0;
            sb.delete();
        end else begin
            e_r0 = (m_cnt == 0) && bus.req0_valid
                   && (!bus.req1_valid || !m_ptr);
            e_r1 = (m_cnt == 0) && bus.req1_valid
                   && (!bus.req0_valid || m_ptr);
            chk("rdy0", 32'(bus.req0_ready), 32'(e_r0));
            chk("rdy1", 32'(bus.req1_ready), 32'(e_r1));
            chk("busy", 32'(busy), 32'(m_cnt != 0));
            chk("done", 32'(done), 32'(m_cnt == 1));
            if (m_cnt == 1) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("q_done", 32'(q), 32'(e.q));
                    chk("err_done", 32'(err), 32'(e.err));
                    m_q = e.q;
                end
            end else begin
                chk("q_hold", 32'(q), 32'(m_q));
                chk("err_idle", 32'(err), 32'h0);
            end
            if (e_r0 || e_r1) begin
                a_op   = e_r1 ? bus.req1_op : bus.req0_op;
                a_idx  = e_r1 ? bus.req1_idx : bus.req0_idx;
                ne.q   = apply(m_q, a_op, a_idx);
                ne.err = (a_op == 2'b00);
                sb.push_back(ne);
                m_ptr = ~e_r1;
                m_cnt = 2;
                acc_id.push_back(e_r1 ? 1 : 0);
                acc_cyc.push_back(cyc);
                if (e_r1) n_acc1++;
                else n_acc0++;
            end else if (m_cnt != 0) begin
                m_cnt--;
            end
        end
    end

    // requesters hold valid until the model sees their accept
    initial begin
        int pop0;
        int pop1;
        pop0 = 0;
        pop1 = 0;
        bus.req0_valid = 1'b0;
        bus.req0_op    = 2'b00;
        bus.req0_idx   = 3'd0;
        bus.req1_valid = 1'b0;
        bus.req1_op    = 2'b00;
        bus.req1_idx   = 3'd0;
        forever begin
            @(posedge clk);
            #1;
            while (pop0 < n_acc0) begin
                void'(cq0.pop_front());
                pop0++;
            end
            while (pop1 < n_acc1) begin
                void'(cq1.pop_front());
                pop1++;
            end
            bus.req0_valid = (cq0.size() != 0);
            if (cq0.size() != 0) begin
                bus.req0_op  = cq0[0].op;
                bus.req0_idx = cq0[0].idx;
            end
            bus.req1_valid = (cq1.size() != 0);
            if (cq1.size() != 0) begin
                bus.req1_op  = cq1[0].op;
                bus.req1_idx = cq1[0].idx;
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((cq0.size() != 0 || cq1.size() != 0 || m_cnt != 0)
               && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("idle_timeout", 32'(n < budget), 32'h1);
    endtask

    task automatic push(input int id, input logic [1:0] op,
                        input logic [2:0] idx);
        cmd_t c;
        c.op  = op;
        c.idx = idx;
        if (id == 1) cq1.push_back(c);
        else cq0.push_back(c);
    endtask

    initial begin
        int a;
        int n;
        int c_rel;
        rst = 1'b0;

        // single SET from req0 right after reset
        push(0, 2'b01, 3'd3);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        c_rel = cyc;
        wait_idle(40);
        chk("set3_q", 32'(q), 32'h08);
        chk("set3_first_acc", 32'(acc_cyc.size() > 0 ? acc_cyc[0] : -1),
            32'(c_rel));

        // both requesters valid out of reset
        @(posedge clk);
        #1 rst = 1'b0;
        acc_id.delete();
        push(0, 2'b01, 3'd0);
        push(1, 2'b01, 3'd7);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        wait_idle(40);
        chk("both_q", 32'(q), 32'h81);
        chk("both_n", 32'(acc_id.size()), 32'd2);
        if (acc_id.size() >= 2) begin
            chk("both_id0", 32'(acc_id[0]), 32'd0);
            chk("both_id1", 32'(acc_id[1]), 32'd1);
        end

        // toggles from req1, then NOP, then no-op SET/CLR
        push(1, 2'b11, 3'd0);
        push(1, 2'b11, 3'd1);
        wait_idle(40);
        chk("tgl_q", 32'(q), 32'h82);
        push(0, 2'b00, 3'd5);
        wait_idle(40);
        chk("nop_q", 32'(q), 32'h82);
        push(0, 2'b10, 3'd6);
        push(1, 2'b01, 3'd1);
        wait_idle(40);
        chk("redundant_q", 32'(q), 32'h82);

        // reset lands in APPLY of SET idx=2
        a = n_acc0;
        n = 0;
        push(0, 2'b01, 3'd2);
        while (n_acc0 == a && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_acc_timeout", 32'(n < 20), 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_q", 32'(q), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);

        // lone requester back-to-back, loaded during reset
        acc_id.delete();
        acc_cyc.delete();
        push(0, 2'b01, 3'd4);
        push(0, 2'b01, 3'd5);
        push(0, 2'b10, 3'd4);
        push(0, 2'b11, 3'd7);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        c_rel = cyc;
        wait_idle(60);
        chk("b2b_q", 32'(q), 32'hA0);
        chk("b2b_n", 32'(acc_cyc.size()), 32'd4);
        if (acc_cyc.size() == 4) begin
            chk("b2b_first", 32'(acc_cyc[0]), 32'(c_rel));
            for (int i = 1; i < 4; i++) begin
                chk("b2b_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
                chk("b2b_id", 32'(acc_id[i]), 32'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
